// File: rtl/ssp_arb_pkg.sv
// rtl/ssp_arb_pkg.sv - shared types and widths for the ssp_uart register-port arbiter
package ssp_arb_pkg;

    localparam int SSP_AW = 3;
    localparam int SSP_DW = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic              wnr;
        logic [SSP_AW-1:0] addr;
        logic [SSP_DW-1:0] wdata;
    } ssp_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin picker; a tie goes to the port that did not win last
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    assign win[0] = req[0] & (~req[1] | last);
    assign win[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/ssp_uart_arbiter.sv
// rtl/ssp_uart_arbiter.sv - shares the ssp_uart register port between host config (0) and streamer (1)
module ssp_uart_arbiter
    import ssp_arb_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int AW           = SSP_AW,
    parameter int DW           = SSP_DW
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [1:0]      req_i,
    input  logic [1:0]      wnr_i,
    input  logic [2*AW-1:0] addr_i,
    input  logic [2*DW-1:0] wdata_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      done_o,
    output logic [DW-1:0]   rdata_o,
    output logic            busy_o,
    output logic            SSP_SSEL,
    output logic [AW-1:0]   SSP_RA,
    output logic            SSP_WnR,
    output logic [DW-1:0]   SSP_DI,
    output logic            SSP_EOC,
    input  logic [DW-1:0]   SSP_DO
);

    state_t          r_state;
    logic            r_last;
    logic            r_owner;
    logic [3:0]      r_cnt;
    logic            r_ssel;
    logic            r_eoc;
    logic [AW-1:0]   r_ra;
    logic            r_wnr;
    logic [DW-1:0]   r_di;
    logic [DW-1:0]   r_rdata;
    logic [1:0]      r_done;

    logic [1:0]      w_win;
    logic            w_sel;
    logic            w_wnr;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;

    rr_arb2 u_rr_arb2 (
        .req  (req_i),
        .last (r_last),
        .win  (w_win)
    );

    assign w_sel   = w_win[1];
    assign w_wnr   = w_sel ? wnr_i[1] : wnr_i[0];
    assign w_addr  = w_sel ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
    assign w_wdata = w_sel ? wdata_i[2*DW-1:DW] : wdata_i[DW-1:0];

    // Grant is a same-cycle decode of the IDLE pick; held off while reset is asserted
    assign gnt_o    = (r_state == IDLE && Rst_n) ? w_win : 2'b00;
    assign done_o   = r_done;
    assign rdata_o  = r_rdata;
    assign busy_o   = (r_state != IDLE);
    assign SSP_SSEL = r_ssel;
    assign SSP_EOC  = r_eoc;
    assign SSP_RA   = r_ra;
    assign SSP_WnR  = r_wnr;
    assign SSP_DI   = r_di;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_cnt   <= 4'd0;
            r_ssel  <= 1'b0;
            r_eoc   <= 1'b0;
            r_ra    <= '0;
            r_wnr   <= 1'b0;
            r_di    <= '0;
            r_rdata <= '0;
            r_done  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 2'b00;
                    if (|w_win) begin
                        r_owner <= w_sel;
                        r_last  <= w_sel;
                        r_ra    <= w_addr;
                        r_wnr   <= w_wnr;
                        r_di    <= w_wnr ? w_wdata : '0;
                        r_cnt   <= 4'(SETUP_CYCLES - 1);
                        r_ssel  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_eoc   <= 1'b1;
                        r_state <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    r_eoc  <= 1'b0;
                    r_ssel <= 1'b0;
                    if (!r_wnr) begin
                        r_rdata <= SSP_DO;
                    end
                    r_done  <= r_owner ? 2'b10 : 2'b01;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 2'b00;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_eoc_ssel: assert property (@(posedge Clk) disable iff (!Rst_n) SSP_EOC |-> SSP_SSEL);
    a_gnt_1h:   assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(gnt_o));
    a_done_1h:  assert property (@(posedge Clk) disable iff (!Rst_n) $onehot0(done_o));
    a_gnt_idle: assert property (@(posedge Clk) disable iff (!Rst_n) (gnt_o != 2'b00) |-> (r_state == IDLE));

endmodule

// File: tb/tb_ssp_uart_arbiter.sv
// tb/tb_ssp_uart_arbiter.sv - scoreboard bench for ssp_uart_arbiter at SETUP_CYCLES 1 and 4
module tb_ssp_uart_arbiter;
    import ssp_arb_pkg::*;

    typedef struct packed {
        logic        dut;
        logic        port;
        ssp_req_t    op;
        logic [11:0] rdata;
        logic        b2b;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req   [2];
    logic [1:0]  wnr   [2];
    logic [5:0]  addr  [2];
    logic [23:0] wdata [2];
    logic [11:0] sdo   [2];
    logic [1:0]  gnt   [2];
    logic [1:0]  done  [2];
    logic [11:0] rdata [2];
    logic        busy  [2];
    logic        ssel  [2];
    logic [2:0]  ra    [2];
    logic        wnr_o [2];
    logic [11:0] di    [2];
    logic        eoc   [2];

    exp_t        sb[$];
    logic [11:0] last_rd [2];
    int          total = 0;
    int          bad   = 0;

    ssp_uart_arbiter #(.SETUP_CYCLES(1), .AW(3), .DW(12)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .req_i(req[0]), .wnr_i(wnr[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .gnt_o(gnt[0]), .done_o(done[0]), .rdata_o(rdata[0]),
        .busy_o(busy[0]), .SSP_SSEL(ssel[0]), .SSP_RA(ra[0]), .SSP_WnR(wnr_o[0]),
        .SSP_DI(di[0]), .SSP_EOC(eoc[0]), .SSP_DO(sdo[0])
    );

    ssp_uart_arbiter #(.SETUP_CYCLES(4), .AW(3), .DW(12)) u_dut4 (
        .Clk(clk), .Rst_n(rst_n), .req_i(req[1]), .wnr_i(wnr[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .gnt_o(gnt[1]), .done_o(done[1]), .rdata_o(rdata[1]),
        .busy_o(busy[1]), .SSP_SSEL(ssel[1]), .SSP_RA(ra[1]), .SSP_WnR(wnr_o[1]),
        .SSP_DI(di[1]), .SSP_EOC(eoc[1]), .SSP_DO(sdo[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input logic d);
        foreach (sb[i]) begin
            if (sb[i].dut == d) return i;
        end
        return -1;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_mon
        localparam int S = (d == 0) ? 1 : 4;
        int   cyc = 0;
        int   tg = 0;
        int   last_done = 0;
        int   idx;
        bit   inflt = 0;
        exp_t e;

        always @(negedge clk) begin
            cyc = cyc + 1;
            if (!rst_n) begin
                inflt = 0;
            end else begin
                if (gnt[d] != 2'b00) begin
                    idx = find(d);
                    if (inflt || idx < 0) begin
                        chk("gnt_unexpected", 32'(gnt[d]), 0);
                    end else begin
                        e = sb[idx];
                        chk("gnt_port", 32'(gnt[d]), e.port ? 2 : 1);
                        if (e.b2b) chk("gnt_b2b_cycle", cyc, last_done + 1);
                        tg = cyc;
                        inflt = 1;
                    end
                end else if (inflt && cyc > tg) begin
                    chk("ssel", 32'(ssel[d]), 32'(cyc <= tg + S + 1));
                    chk("eoc", 32'(eoc[d]), 32'(cyc == tg + S + 1));
                    chk("busy", 32'(busy[d]), 1);
                    if (eoc[d]) begin
                        chk("ra", 32'(ra[d]), 32'(e.op.addr));
                        chk("wnr", 32'(wnr_o[d]), 32'(e.op.wnr));
                        chk("di", 32'(di[d]), e.op.wnr ? 32'(e.op.wdata) : 0);
                    end
                    if (cyc == tg + S + 2) begin
                        chk("done", 32'(done[d]), e.port ? 2 : 1);
                        chk("rdata", 32'(rdata[d]), 32'(e.rdata));
                        idx = find(d);
                        if (idx >= 0) sb.delete(idx);
                        inflt = 0;
                        last_done = cyc;
                    end
                end else if (done[d] != 2'b00) begin
                    chk("done_unexpected", 32'(done[d]), 0);
                end
            end
        end
    end

    function automatic exp_t mk(input logic d, input logic p, input logic w,
                                input logic [2:0] a, input logic [11:0] wd, input logic b2b);
        exp_t e;
        e.dut      = d;
        e.port     = p;
        e.op.wnr   = w;
        e.op.addr  = a;
        e.op.wdata = wd;
        e.rdata    = last_rd[d];
        e.b2b      = b2b;
        return e;
    endfunction

    task automatic set_op(input int d, input int p, input logic w, input logic [2:0] a, input logic [11:0] wd);
        wnr[d][p]          = w;
        addr[d][p*3 +: 3]  = a;
        wdata[d][p*12 +: 12] = wd;
    endtask

    task automatic count_gnt(input int d, input int n);
        int c = 0;
        for (int k = 0; k < 200 && c < n; k++) begin
            @(negedge clk);
            #1;
            if (gnt[d] != 2'b00) c++;
        end
        chk("gnt_count", c, n);
    endtask

    task automatic wait_empty(input int d);
        for (int n = 0; n < 100 && find(1'(d)) >= 0; n++) begin
            @(negedge clk);
            #1;
        end
        chk("sb_drained", 32'(find(1'(d)) >= 0), 0);
        @(posedge clk);
        #1;
    endtask

    // One access from one port: raise req, drop it right after grant and scramble operands
    task automatic do_access(input int d, input int p, input logic w, input logic [2:0] a,
                             input logic [11:0] wd, input logic [11:0] sdo_v);
        if (!w) last_rd[d] = sdo_v;
        sb.push_back(mk(1'(d), 1'(p), w, a, wd, 1'b0));
        sdo[d] = sdo_v;
        set_op(d, p, w, a, wd);
        req[d][p] = 1'b1;
        count_gnt(d, 1);
        @(posedge clk);
        #1;
        req[d][p] = 1'b0;
        set_op(d, p, ~w, ~a, ~wd);
        wait_empty(d);
        sdo[d] = 12'h333;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 2'b00; wnr[d] = 2'b00; addr[d] = '0; wdata[d] = '0;
            sdo[d] = 12'h333; last_rd[d] = 12'h000;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_rdata", 32'(rdata[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_ssel", 32'(ssel[0]), 0);
        chk("rst_eoc", 32'(eoc[0]), 0);
        chk("rst_bus", {ra[0], wnr_o[0], di[0]}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_access(0, 0, 1'b1, 3'h4, 12'hDED, 12'h333);
        do_access(0, 1, 1'b0, 3'h2, 12'hFFF, 12'h5A5);
        do_access(0, 1, 1'b1, 3'h3, 12'h123, 12'h333);

        // Four back-to-back grants with both ports holding req; last winner was port 1
        set_op(0, 0, 1'b1, 3'h1, 12'h111);
        set_op(0, 1, 1'b1, 3'h5, 12'hAAA);
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 3'h1, 12'h111, 1'b0));
        sb.push_back(mk(1'b0, 1'b1, 1'b1, 3'h5, 12'hAAA, 1'b1));
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 3'h1, 12'h111, 1'b1));
        sb.push_back(mk(1'b0, 1'b1, 1'b1, 3'h5, 12'hAAA, 1'b1));
        req[0] = 2'b11;
        count_gnt(0, 4);
        @(posedge clk);
        #1;
        req[0] = 2'b00;
        wait_empty(0);

        do_access(1, 0, 1'b0, 3'h6, 12'h000, 12'h3C3);
        do_access(0, 1, 1'b1, 3'h7, 12'h0F0, 12'h333);

        // Reset while the access sits in SETUP
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 3'h1, 12'h321, 1'b0));
        set_op(0, 0, 1'b1, 3'h1, 12'h321);
        req[0] = 2'b01;
        count_gnt(0, 1);
        @(posedge clk);
        #2;
        req[0] = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst_ssel", 32'(ssel[0]), 0);
        chk("midrst_eoc", 32'(eoc[0]), 0);
        chk("midrst_busy", 32'(busy[0]), 0);
        sb.delete();
        last_rd[0] = 12'h000;
        req[0] = 2'b11;
        set_op(0, 1, 1'b1, 3'h2, 12'h456);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("midrst_gnt", 32'(gnt[0]), 0);
            chk("midrst_done", 32'(done[0]), 0);
        end
        chk("midrst_rdata", 32'(rdata[0]), 0);
        @(posedge clk);
        #1;
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 3'h1, 12'h321, 1'b0));
        sb.push_back(mk(1'b0, 1'b1, 1'b1, 3'h2, 12'h456, 1'b1));
        rst_n = 1'b1;
        count_gnt(0, 2);
        @(posedge clk);
        #1;
        req[0] = 2'b00;
        wait_empty(0);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssp_uart_arbiter.md
Name: ssp_uart_arbiter

Overview:
- Shares the single ssp_uart register port (SSP_SSEL/SSP_RA/SSP_WnR/SSP_DI/SSP_EOC/SSP_DO) between two requesters: host config (port 0) and TX/RX streamer (port 1).
- Round-robin arbitration between the two ports.
- Sequences each access as SETUP then ACCESS then DONE.
- Sits between the requesters and ssp_uart in hdl_top.

Parameters:
- SETUP_CYCLES, 1, cycles SSP_SSEL is asserted with the bus stable before SSP_EOC; legal range 1..15.
- AW, 3, SSP register address width.
- DW, 12, SSP data width.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- req_i  in  2  per-port request level.
- wnr_i  in  2  per-port direction: 1 = write, 0 = read.
- addr_i  in  2xAW  per-port register address.
- wdata_i  in  2xDW  per-port write data.
- gnt_o  out  2  one-cycle pulse: request accepted, operands latched.
- done_o  out  2  one-cycle pulse: access complete.
- rdata_o  out  DW  read data; valid when done_o is set for a read.
- busy_o  out  1  high whenever state != IDLE.
- SSP_SSEL  out  1  slave select to ssp_uart.
- SSP_RA  out  AW  register address.
- SSP_WnR  out  1  write/read strobe qualifier.
- SSP_DI  out  DW  write data.
- SSP_EOC  out  1  end-of-cycle strobe.
- SSP_DO  in  DW  read data from ssp_uart.

Behaviour:
- Reset: every output is 0, state = IDLE, last_gnt = 1. With last_gnt = 1, port 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req_i bit is set, pick a winner.
  - Only one requester: that port wins.
  - Both requesters: the port != last_gnt wins.
  - In the same cycle: pulse gnt_o[winner], latch addr/wnr/wdata/owner, update last_gnt, go to SETUP with cnt = SETUP_CYCLES-1.
- SETUP:
  - SSP_SSEL = 1.
  - SSP_RA, SSP_WnR and SSP_DI driven from the latched operands.
  - When cnt = 0, go to ACCESS; otherwise decrement cnt.
- ACCESS (exactly 1 cycle):
  - SSP_SSEL = 1, SSP_EOC = 1, bus unchanged.
  - On a read, capture SSP_DO at the end of the cycle.
- DONE (1 cycle):
  - SSP_SSEL = 0, SSP_EOC = 0.
  - Pulse done_o[owner]; return to IDLE.
- Bus hold rules:
  - SSP_RA, SSP_WnR and SSP_DI keep their last values in IDLE and DONE.
  - SSP_DI is forced to 0 on reads.
- rdata_o:
  - Updated only by reads.
  - Holds its value across writes and idle cycles.
- Timing:
  - Grant at cycle T; done at T + SETUP_CYCLES + 2.
  - Back-to-back: the next grant is possible in the IDLE cycle at T + SETUP_CYCLES + 3.
  - Peak rate is one access per SETUP_CYCLES + 3 cycles.
- Requester rules:
  - Operands may change after gnt_o.
  - A requester that drops req_i after grant still gets done_o; the transaction always completes.
  - A req_i still high in the IDLE cycle after done_o counts as a new request.
- Requests arriving outside IDLE are ignored until IDLE and are never lost while held.
- gnt_o and done_o are one-hot or zero; never both bits set.
- Reset mid-transaction: SSP_SSEL and SSP_EOC drop asynchronously; no done_o is issued; the FSM restarts in IDLE.
- Assertions:
  - SSP_EOC implies SSP_SSEL.
  - $onehot0(gnt_o) and $onehot0(done_o).
  - No gnt_o unless state == IDLE.

Decomposition:
- Package ssp_arb_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SETUP, ACCESS, DONE};
  - localparams SSP_AW = 3, SSP_DW = 12;
  - typedef struct ssp_req_t {wnr, addr, wdata}.
- One sub-module, rr_arb2: a 2-way round-robin picker. Inputs: req[1:0], last. Output: one-hot win[1:0]. Purely combinational.

Test Plan:
1. Single write, SETUP_CYCLES = 1: port 0 writes addr 3'h4, data 12'hDED.
   - Response: gnt_o = 01 at T; SSEL high T+1..T+2; EOC high T+2 with RA = 4, WnR = 1, DI = DED; done_o = 01 at T+3.
2. Read: port 1 reads addr 3'h2 while SSP_DO = 12'h5A5 in ACCESS.
   - Response: done_o = 10 with rdata_o = 12'h5A5.
   - A following write leaves rdata_o = 12'h5A5.
3. Contention: both ports hold req_i = 11 continuously, port 1 writing 12'hAAA.
   - Response: grant order 0, 1, 0, 1; each grant in the IDLE cycle after the previous done.
4. SETUP_CYCLES = 4: single read.
   - Response: SSEL high for 5 cycles; EOC only in the 5th; done exactly 6 cycles after gnt.
5. Requester drops req_i the cycle after gnt.
   - Response: the access completes and done_o is still pulsed.
6. Assert Rst_n = 0 during SETUP.
   - Response: SSP_SSEL = 0 immediately; no done_o; after release, a port 0/port 1 tie is granted to port 0.
